// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The LSU connects through the slave modport; the requester and memory use master.
interface load_store_unit_if #(parameter int B_WIDTH = 32);
    logic               req_valid;
    logic               req_ready;
    logic               req_is_store;
    logic [2:0]         funct3;
    logic [B_WIDTH-1:0] base_addr;
    logic [B_WIDTH-1:0] offset;
    logic [B_WIDTH-1:0] store_data;
    logic               resp_valid;
    logic [B_WIDTH-1:0] load_data;
    logic               misaligned;
    logic               illegal;
    logic [B_WIDTH-1:0] mem_addr;
    logic               mem_read_en;
    logic               mem_write_en;
    logic [3:0]         write_byte_en;
    logic [B_WIDTH-1:0] mem_wdata;
    logic [B_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_store, funct3, base_addr, offset, store_data, mem_rdata,
        output req_ready, resp_valid, load_data, misaligned, illegal,
               mem_addr, mem_read_en, mem_write_en, write_byte_en, mem_wdata
    );

    modport master (
        output req_valid, req_is_store, funct3, base_addr, offset, store_data, mem_rdata,
        input  req_ready, resp_valid, load_data, misaligned, illegal,
               mem_addr, mem_read_en, mem_write_en, write_byte_en, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-indexed data memory with
// byte lanes, alignment and funct3 checking, sign/zero extension of loads.
module load_store_unit #(
    parameter int B_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR, RESP} state_t;

    state_t             r_state, w_next;
    logic [B_WIDTH-1:0] r_ea, r_sd, r_load_data;
    logic [2:0]         r_f3;
    logic               r_mis, r_ill;

    logic [B_WIDTH-1:0] w_ea, w_lane, w_ext;
    logic               w_accept, w_ill, w_mis;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_ea     = bus.base_addr + bus.offset;

    // Illegal wins over misaligned so at most one fault flag is ever raised.
    always_comb begin
        if (bus.req_is_store)
            w_ill = (bus.funct3 == 3'b011) || bus.funct3[2];
        else
            w_ill = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
        w_mis = !w_ill && (((bus.funct3[1:0] == 2'b01) && w_ea[0]) ||
                           ((bus.funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00)));
    end

    assign w_lane = bus.mem_rdata >> {r_ea[1:0], 3'b000};

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {24'd0, w_lane[7:0]};
            3'b101:  w_ext = {16'd0, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ea        <= '0;
            r_sd        <= '0;
            r_f3        <= '0;
            r_mis       <= 1'b0;
            r_ill       <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ea  <= w_ea;
                r_sd  <= bus.store_data;
                r_f3  <= bus.funct3;
                r_mis <= w_mis;
                r_ill <= w_ill;
            end
            if (r_state == RD_CAPTURE)
                r_load_data <= w_ext;
        end
    end

    always_comb begin
        w_next            = r_state;
        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.misaligned    = 1'b0;
        bus.illegal       = 1'b0;
        bus.mem_read_en   = 1'b0;
        bus.mem_write_en  = 1'b0;
        bus.write_byte_en = 4'b0000;
        bus.mem_wdata     = '0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    if (w_ill || w_mis)        w_next = RESP;
                    else if (bus.req_is_store) w_next = WR;
                    else                       w_next = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                bus.mem_read_en = 1'b1;
                w_next          = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                bus.mem_read_en = 1'b1;
                w_next          = RESP;
            end
            WR: begin
                bus.mem_write_en = 1'b1;
                case (r_f3[1:0])
                    2'b00: begin
                        bus.write_byte_en = 4'b0001 << r_ea[1:0];
                        bus.mem_wdata     = {4{r_sd[7:0]}};
                    end
                    2'b01: begin
                        bus.write_byte_en = 4'b0011 << r_ea[1:0];
                        bus.mem_wdata     = {2{r_sd[15:0]}};
                    end
                    default: begin
                        bus.write_byte_en = 4'b1111;
                        bus.mem_wdata     = r_sd;
                    end
                endcase
                w_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.misaligned = r_mis;
                bus.illegal    = r_ill;
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.load_data = r_load_data;
    assign bus.mem_addr  = {2'b00, r_ea[B_WIDTH-1:2]};
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane memory model and a
// response scoreboard checked by a negedge monitor.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_mem = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.B_WIDTH(32)) bus();
    load_store_unit #(.B_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[4] <= 32'h8086F00D;
        end else begin
            if (bus.mem_read_en) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
            if (bus.mem_write_en)
                for (int b = 0; b < 4; b++)
                    if (bus.write_byte_en[b]) mem[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    typedef struct { logic [31:0] ld; logic mis; logic ill; } exp_t;
    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_be      = '0;
    logic [31:0] last_wdata   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_read_en) begin rd_cnt++; last_rd_addr = bus.mem_addr; end
        if (bus.mem_write_en) begin wr_cnt++; last_be = 32'(bus.write_byte_en); last_wdata = bus.mem_wdata; end
        if (bus.mem_read_en || bus.mem_write_en)
            chk("strobe_excl", 32'(bus.mem_read_en & bus.mem_write_en), 32'd0);
        if (bus.resp_valid) begin
            chk("resp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_load_data", bus.load_data, e.ld);
                chk("sb_misaligned", 32'(bus.misaligned), 32'(e.mis));
                chk("sb_illegal", 32'(bus.illegal), 32'(e.ill));
            end
        end else begin
            chk("flags_idle", 32'({bus.misaligned, bus.illegal}), 32'd0);
        end
    end

    task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                         input int exp_lat, input logic [31:0] exp_ld, input logic exp_mis,
                         input logic exp_ill, input int exp_rd, input int exp_wr);
        exp_t e;
        int rd0, wr0, lat;
        bit got;
        e.ld = exp_ld; e.mis = exp_mis; e.ill = exp_ill;
        sb.push_back(e);
        @(negedge clk);
        bus.req_is_store = st; bus.funct3 = f3; bus.base_addr = base;
        bus.offset = off; bus.store_data = sd; bus.req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        #1 bus.req_valid = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) begin got = 1; break; end
        end
        chk({tag, "_resp"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        chk({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        bus.req_valid = 0; bus.req_is_store = 0; bus.funct3 = 0;
        bus.base_addr = 0; bus.offset = 0; bus.store_data = 0; bus.mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_strobes", 32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
        chk("rst_load_data", bus.load_data, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_be_wdata", 32'(bus.write_byte_en) | bus.mem_wdata, 32'd0);
        rst = 1'b0; init_mem = 1'b0;

        issue("lb", 0, 3'b000, 32'h10, 32'd1, 0, 3, 32'hFFFFFFF0, 0, 0, 2, 0);
        chk("lb_mem_addr", last_rd_addr, 32'd4);
        issue("lhu", 0, 3'b101, 32'h14, 32'hFFFFFFFE, 0, 3, 32'h00008086, 0, 0, 2, 0);
        issue("sb", 1, 3'b000, 32'h10, 32'd3, 32'h123456AB, 2, 32'h00008086, 0, 0, 0, 1);
        chk("sb_be", last_be, 32'b1000);
        chk("sb_wdata", last_wdata, 32'hABABABAB);
        issue("lw", 0, 3'b010, 32'h10, 32'd0, 0, 3, 32'hAB86F00D, 0, 0, 2, 0);
        issue("lw_mis", 0, 3'b010, 32'h10, 32'd6, 0, 1, 32'hAB86F00D, 1, 0, 0, 0);
        issue("st_ill", 1, 3'b011, 32'h10, 32'd0, 32'h55, 1, 32'hAB86F00D, 0, 1, 0, 0);
        issue("sh", 1, 3'b001, 32'h10, 32'd2, 32'h1234BEEF, 2, 32'hAB86F00D, 0, 0, 0, 1);
        chk("sh_be", last_be, 32'b1100);
        chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
        issue("lh", 0, 3'b001, 32'h10, 32'd2, 0, 3, 32'hFFFFBEEF, 0, 0, 2, 0);
        issue("lb_pos", 0, 3'b000, 32'h10, 32'd0, 0, 3, 32'h0000000D, 0, 0, 2, 0);
        issue("lbu", 0, 3'b100, 32'h10, 32'd3, 0, 3, 32'h000000BE, 0, 0, 2, 0);
        issue("ld_ill_pri", 0, 3'b110, 32'h10, 32'd1, 0, 1, 32'h000000BE, 0, 1, 0, 0);
        issue("sh_mis", 1, 3'b001, 32'h10, 32'd1, 32'h7777, 1, 32'h000000BE, 1, 0, 0, 0);
        issue("sw", 1, 3'b010, 32'h20, 32'd0, 32'hCAFEBABE, 2, 32'h000000BE, 0, 0, 0, 1);
        chk("sw_be", last_be, 32'b1111);
        chk("sw_wdata", last_wdata, 32'hCAFEBABE);
        issue("lw_sw", 0, 3'b010, 32'h1C, 32'd4, 0, 3, 32'hCAFEBABE, 0, 0, 2, 0);

        // Abort a load in RD_CAPTURE; no response entry is queued for it.
        @(negedge clk);
        bus.req_is_store = 0; bus.funct3 = 3'b010; bus.base_addr = 32'h10;
        bus.offset = 0; bus.req_valid = 1'b1;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_capture", 32'(bus.mem_read_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_read_en", 32'(bus.mem_read_en), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_load_data", bus.load_data, 32'd0);
        repeat (4) @(negedge clk);
        issue("lw_after_rst", 0, 3'b010, 32'h10, 32'd0, 0, 3, 32'hBEEFF00D, 0, 0, 2, 0);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
